// File: rtl/traffic_conflict_monitor_if.sv
// Signal bundle between the traffic light controller, the conflict monitor and the lamp drivers.
// fault_cnt is present only when FAULT_CNT_EN is defined.
interface traffic_conflict_monitor_if;
  logic [2:0] n_lights_in;
  logic [2:0] s_lights_in;
  logic [2:0] e_lights_in;
  logic [2:0] w_lights_in;
  logic       fault_clr;
  logic [2:0] n_lamp;
  logic [2:0] s_lamp;
  logic [2:0] e_lamp;
  logic [2:0] w_lamp;
  logic       fault;
  logic [2:0] fault_code;
`ifdef FAULT_CNT_EN
  logic [7:0] fault_cnt;

  modport master (
    output n_lights_in, s_lights_in, e_lights_in, w_lights_in, fault_clr,
    input  n_lamp, s_lamp, e_lamp, w_lamp, fault, fault_code, fault_cnt
  );

  modport slave (
    input  n_lights_in, s_lights_in, e_lights_in, w_lights_in, fault_clr,
    output n_lamp, s_lamp, e_lamp, w_lamp, fault, fault_code, fault_cnt
  );
`else
  modport master (
    output n_lights_in, s_lights_in, e_lights_in, w_lights_in, fault_clr,
    input  n_lamp, s_lamp, e_lamp, w_lamp, fault, fault_code
  );

  modport slave (
    input  n_lights_in, s_lights_in, e_lights_in, w_lights_in, fault_clr,
    output n_lamp, s_lamp, e_lamp, w_lamp, fault, fault_code
  );
`endif
endinterface

// File: rtl/traffic_conflict_monitor.sv
// Safety stage between light controller and lamp drivers: latches faults and flashes red.
// Optional saturating fault-entry counter enabled by defining FAULT_CNT_EN.
module traffic_conflict_monitor #(
  parameter int unsigned FLASH_DIV    = 4,
  parameter int unsigned CLEAR_CYCLES = 8
) (
  input logic                       clk,
  input logic                       rst_a,
  traffic_conflict_monitor_if.slave bus
);

  localparam int unsigned BlinkW = $clog2(2 * FLASH_DIV);
  localparam int unsigned CleanW = $clog2(CLEAR_CYCLES + 1);
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(2 * FLASH_DIV - 1);
  localparam logic [BlinkW-1:0] RedLast  = BlinkW'(FLASH_DIV - 1);
  localparam logic [CleanW-1:0] CleanMax = CleanW'(CLEAR_CYCLES);

  localparam logic [2:0] Green  = 3'b001;
  localparam logic [2:0] Yellow = 3'b010;
  localparam logic [2:0] Red    = 3'b100;
  localparam logic [2:0] Dark   = 3'b000;

  typedef enum logic [1:0] {StRun, StFlash, StRecover} state_e;

  state_e            state_q, state_d;
  logic [3:0][2:0]   in_d, in_q, prev_q;
  logic [3:0][2:0]   lamp_q, lamp_d;
  logic              fault_q, fault_d;
  logic [2:0]        code_q, code_d;
  logic [BlinkW-1:0] blink_q, blink_d, blink_nxt;
  logic [CleanW-1:0] clean_q, clean_d, clean_inc;
  logic [2:0]        fault_now;
  logic [2:0]        n_active;
  logic              illegal, bad_step;
  logic [3:0][2:0]   flash_lamps;

  // Index 0 is north, then south, east, west.
  assign in_d = {bus.w_lights_in, bus.e_lights_in, bus.s_lights_in, bus.n_lights_in};

  always_comb begin
    illegal  = 1'b0;
    bad_step = 1'b0;
    n_active = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (!(in_q[i] inside {Green, Yellow, Red})) illegal = 1'b1;
      if (in_q[i] != Red) n_active = n_active + 3'd1;
      if (!((in_q[i] == prev_q[i]) ||
            (prev_q[i] == Green  && in_q[i] == Yellow) ||
            (prev_q[i] == Yellow && in_q[i] == Red) ||
            (prev_q[i] == Red    && in_q[i] == Green))) begin
        bad_step = 1'b1;
      end
    end
    if (illegal)            fault_now = 3'd1;
    else if (n_active > 1)  fault_now = 3'd2;
    else if (bad_step)      fault_now = 3'd3;
    else                    fault_now = 3'd0;
  end

  assign blink_nxt   = (blink_q == BlinkMax) ? '0 : blink_q + 1'b1;
  assign flash_lamps = (blink_nxt <= RedLast) ? {4{Red}} : {4{Dark}};
  assign clean_inc   = (clean_q == CleanMax) ? clean_q : clean_q + 1'b1;

  always_comb begin
    state_d = state_q;
    lamp_d  = lamp_q;
    fault_d = fault_q;
    code_d  = code_q;
    blink_d = blink_q;
    clean_d = clean_q;
    unique case (state_q)
      StRun: begin
        if (fault_now != 3'd0) begin
          state_d = StFlash;
          lamp_d  = {4{Red}};
          fault_d = 1'b1;
          code_d  = fault_now;
          blink_d = '0;
        end else begin
          lamp_d = in_q;
        end
      end
      StFlash: begin
        // Faults are ignored here; the latched code stays until recovery completes.
        blink_d = blink_nxt;
        lamp_d  = flash_lamps;
        if (bus.fault_clr) begin
          state_d = StRecover;
          clean_d = '0;
        end
      end
      StRecover: begin
        if (fault_now != 3'd0) begin
          state_d = StFlash;
          code_d  = fault_now;
          clean_d = '0;
          blink_d = '0;
          lamp_d  = {4{Red}};
        end else if (clean_inc == CleanMax) begin
          // The CLEAR_CYCLES-th consecutive clean cycle hands the lamps back.
          state_d = StRun;
          clean_d = clean_inc;
          fault_d = 1'b0;
          code_d  = 3'd0;
          lamp_d  = in_q;
        end else begin
          clean_d = clean_inc;
          blink_d = blink_nxt;
          lamp_d  = flash_lamps;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state_q <= StRun;
      in_q    <= {4{Red}};
      prev_q  <= {4{Red}};
      lamp_q  <= {4{Red}};
      fault_q <= 1'b0;
      code_q  <= 3'd0;
      blink_q <= '0;
      clean_q <= '0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      prev_q  <= in_q;
      lamp_q  <= lamp_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      blink_q <= blink_d;
      clean_q <= clean_d;
    end
  end

  assign bus.n_lamp     = lamp_q[0];
  assign bus.s_lamp     = lamp_q[1];
  assign bus.e_lamp     = lamp_q[2];
  assign bus.w_lamp     = lamp_q[3];
  assign bus.fault      = fault_q;
  assign bus.fault_code = code_q;

`ifdef FAULT_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Every entry to FLASH comes from RUN or RECOVER with a live fault.
  assign cnt_d = (state_q != StFlash && fault_now != 3'd0 && cnt_q != 8'hFF) ?
                 cnt_q + 8'd1 : cnt_q;

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

  assign bus.fault_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Scoreboard bench for traffic_conflict_monitor: a cycle model predicts outputs per driven cycle.
module tb_traffic_conflict_monitor;

  localparam int FD = 4;
  localparam int CC = 8;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;
  localparam logic [11:0] AllRed = 12'h924;

  typedef struct {
    logic [11:0] lamp;
    logic        fault;
    logic [2:0]  code;
    logic [7:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  // Reference model state; m_st 0 run, 1 flash, 2 recover.
  logic [2:0]  m_in[4];
  logic [2:0]  m_prev[4];
  logic [11:0] m_lamp;
  logic        m_fault;
  logic [2:0]  m_code;
  int          m_st, m_t, m_clean, m_cnt;

  traffic_conflict_monitor_if bus();

  traffic_conflict_monitor #(
    .FLASH_DIV   (FD),
    .CLEAR_CYCLES(CC)
  ) dut (
    .clk  (clk),
    .rst_a(rst_a),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [11:0] dut_lamps();
    return {bus.w_lamp, bus.e_lamp, bus.s_lamp, bus.n_lamp};
  endfunction

  function automatic logic [2:0] model_code();
    bit ill = 0;
    bit tr = 0;
    int act = 0;
    for (int i = 0; i < 4; i++) begin
      if (!(m_in[i] == G || m_in[i] == Y || m_in[i] == R)) ill = 1;
      if (m_in[i] != R) act++;
      case ({m_prev[i], m_in[i]})
        {G, G}, {G, Y}, {Y, Y}, {Y, R}, {R, R}, {R, G}: ;
        default: tr = 1;
      endcase
    end
    if (ill) return 3'd1;
    if (act > 1) return 3'd2;
    if (tr) return 3'd3;
    return 3'd0;
  endfunction

  function automatic logic [11:0] flash_of(input int t);
    return (((t / FD) % 2) == 0) ? AllRed : 12'h000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_in[i]   = R;
      m_prev[i] = R;
    end
    m_lamp = AllRed; m_fault = 0; m_code = 0; m_st = 0; m_t = 0; m_clean = 0; m_cnt = 0;
  endtask

  task automatic enter_flash(input logic [2:0] c);
    m_st = 1; m_fault = 1; m_code = c; m_t = 0; m_clean = 0; m_lamp = AllRed;
    if (m_cnt < 255) m_cnt++;
  endtask

  // Called at a negedge: drive one cycle of inputs, predict, then compare after the edge.
  task automatic step(input logic [2:0] n, s, e, w, input logic clr);
    exp_t x;
    logic [2:0] c;
    bus.n_lights_in = n; bus.s_lights_in = s; bus.e_lights_in = e; bus.w_lights_in = w;
    bus.fault_clr = clr;
    c = model_code();
    case (m_st)
      0: if (c != 0) enter_flash(c);
         else m_lamp = {m_in[3], m_in[2], m_in[1], m_in[0]};
      1: begin
        m_t++;
        m_lamp = flash_of(m_t);
        if (clr) begin m_st = 2; m_clean = 0; end
      end
      default: begin
        if (c != 0) enter_flash(c);
        else begin
          m_clean++;
          if (m_clean == CC) begin
            m_st = 0; m_fault = 0; m_code = 0;
            m_lamp = {m_in[3], m_in[2], m_in[1], m_in[0]};
          end else begin
            m_t++;
            m_lamp = flash_of(m_t);
          end
        end
      end
    endcase
    m_prev = m_in;
    m_in = '{n, s, e, w};
    x.lamp = m_lamp; x.fault = m_fault; x.code = m_code; x.cnt = 8'(m_cnt);
    sb.push_back(x);
    @(negedge clk);
    x = sb.pop_front();
    check("lamps", dut_lamps(), x.lamp);
    check("fault", bus.fault, x.fault);
    check("fault_code", bus.fault_code, x.code);
`ifdef FAULT_CNT_EN
    check("fault_cnt", bus.fault_cnt, x.cnt);
`endif
  endtask

  task automatic red(input int k, input logic clr = 1'b0);
    for (int i = 0; i < k; i++) step(R, R, R, R, clr);
  endtask

  task automatic hold_dir(input int d, input logic [2:0] c, input int k);
    logic [2:0] v[4];
    for (int i = 0; i < 4; i++) v[i] = (i == d) ? c : R;
    for (int i = 0; i < k; i++) step(v[0], v[1], v[2], v[3], 1'b0);
  endtask

  // Entered at a negedge; asserts reset between edges so the check observes the async path.
  task automatic do_reset();
    #2 rst_a = 1'b0;
    #1;
    check("rst_lamps", dut_lamps(), AllRed);
    check("rst_fault", bus.fault, 1'b0);
    check("rst_code", bus.fault_code, 3'd0);
`ifdef FAULT_CNT_EN
    check("rst_cnt", bus.fault_cnt, 8'd0);
`endif
    bus.n_lights_in = R; bus.s_lights_in = R; bus.e_lights_in = R; bus.w_lights_in = R;
    bus.fault_clr = 1'b0;
    model_reset();
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b1;
  endtask

  initial begin
    bus.n_lights_in = R; bus.s_lights_in = R; bus.e_lights_in = R; bus.w_lights_in = R;
    bus.fault_clr = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Normal controller cycle N, S, E, W.
    for (int d = 0; d < 4; d++) begin
      hold_dir(d, G, 8);
      hold_dir(d, Y, 4);
    end
    red(3);
    check("t1_fault", bus.fault, 1'b0);

    // Conflict, then flashing pattern.
    step(G, R, G, R, 1'b0);
    red(1);
    check("t2_code", bus.fault_code, 3'd2);
    red(18);

    // Clear with a clean pipeline: RUN on the 8th clean cycle.
    red(1, 1'b1);
    red(7);
    check("t5_still_fault", bus.fault, 1'b1);
    red(1);
    check("t5_run", bus.fault, 1'b0);
    red(2);

    // Conflict during recovery on clean cycle 5.
    step(G, R, G, R, 1'b0);
    red(1);
    red(6);
    red(1, 1'b1);
    red(3);
    step(G, R, G, R, 1'b0);
    red(1);
    check("t5_reflash", bus.fault_code, 3'd2);
    check("t5_reflash_f", bus.fault, 1'b1);
    red(6);
    red(1, 1'b1);
    red(7);
    check("t5_still_fault2", bus.fault, 1'b1);
    red(1);
    check("t5_run2", bus.fault, 1'b0);

    // Green straight to red.
    do_reset();
    hold_dir(0, G, 3);
    red(2);
    check("t3_g2r", bus.fault_code, 3'd3);

    // Yellow back to green.
    do_reset();
    hold_dir(3, G, 2);
    hold_dir(3, Y, 2);
    hold_dir(3, G, 2);
    check("t3_y2g", bus.fault_code, 3'd3);

    // Illegal code beats conflict.
    do_reset();
    step(3'b011, G, G, R, 1'b0);
    red(1);
    check("t4_code", bus.fault_code, 3'd1);

    // Async reset while lamps are dark mid-flash.
    do_reset();
    step(G, R, G, R, 1'b0);
    red(5);
    check("t6_dark", dut_lamps(), 12'h000);
    do_reset();
    red(2);

`ifdef FAULT_CNT_EN
    do_reset();
    for (int k = 0; k < 300; k++) begin
      step(G, R, G, R, 1'b0);
      red(3);
      red(1, 1'b1);
      red(8);
    end
    check("t6_cnt_sat", bus.fault_cnt, 8'd255);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
